uart_transceiver: RTL and testbench

// - Full-duplex 8N1 UART with ready/valid byte interfaces on both sides.
// - Serves as the CPU's on-chip UART and as the off-chip test UART on the serial pins.
// - Transmit path serialises DataIn onto SOut; receive path deserialises SIn into DataOut.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_transceiver.sv | 169 ++++++++++++++++
 tb/tb_uart_transceiver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared frame constants and state encodings for the 8N1 UART transceiver.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Symbol-period counter: Clear restarts the period; SymbolEdge marks the last cycle
// of a bit period, Sample marks the mid-bit sampling point.
module uart_bit_timer #(
  parameter int unsigned SymbolEdgeTime = 434
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic SymbolEdge,
  output logic Sample
);

  localparam int unsigned SampleTime = SymbolEdgeTime / 2;
  localparam int unsigned CountWidth = $clog2(SymbolEdgeTime + 1);

  logic [CountWidth-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Clear || SymbolEdge) begin
      count <= '0;
    end else begin
      count <= count + CountWidth'(1);
    end
  end

  assign SymbolEdge = (count == CountWidth'(SymbolEdgeTime - 1));
  assign Sample     = (count == CountWidth'(SampleTime - 1));

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with ready/valid byte interfaces.
// Define UART_RX_SYNC_EN to pass SIn through a 2-flop synchroniser before the receiver.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned ClockFreq = 50_000_000,
  parameter int unsigned BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SIn,
  output logic       SOut
);

  localparam int unsigned SymbolEdgeTime = ClockFreq / BaudRate;

  logic rxIn;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rxSync;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxSync <= '1;
    end else begin
      rxSync <= {rxSync[0], SIn};
    end
  end

  assign rxIn = rxSync[1];
`else
  assign rxIn = SIn;
`endif

  // Transmitter
  tx_state_t            txState;
  logic [DATA_BITS:0]   txShift;
  logic [3:0]           txBitCount;
  logic                 txClear;
  logic                 txEdge;
  logic                 txSampleUnused;

  assign txClear = (txState == TX_IDLE);

  uart_bit_timer #(
    .SymbolEdgeTime(SymbolEdgeTime)
  ) txTimer (
    .Clock     (Clock),
    .Reset     (Reset),
    .Clear     (txClear),
    .SymbolEdge(txEdge),
    .Sample    (txSampleUnused)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      txState     <= TX_IDLE;
      txShift     <= '1;
      txBitCount  <= '0;
      DataInReady <= 1'b1;
      SOut        <= IDLE_LEVEL;
    end else begin
      case (txState)
        TX_IDLE: begin
          if (DataInValid && DataInReady) begin
            txShift     <= {IDLE_LEVEL, DataIn};
            txBitCount  <= '0;
            DataInReady <= 1'b0;
            SOut        <= 1'b0;
            txState     <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          // txShift carries the data bits followed by the stop bit
          if (txEdge) begin
            if (txBitCount == 4'(FRAME_BITS - 1)) begin
              txState     <= TX_IDLE;
              DataInReady <= 1'b1;
              SOut        <= IDLE_LEVEL;
            end else begin
              SOut       <= txShift[0];
              txShift    <= {IDLE_LEVEL, txShift[DATA_BITS:1]};
              txBitCount <= txBitCount + 4'd1;
            end
          end
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  // Receiver
  rx_state_t            rxState;
  logic [DATA_BITS-1:0] rxShift;
  logic [2:0]           rxBitCount;
  logic                 rxClear;
  logic                 rxSample;
  logic                 rxEdgeUnused;

  assign rxClear = (rxState == RX_IDLE);

  uart_bit_timer #(
    .SymbolEdgeTime(SymbolEdgeTime)
  ) rxTimer (
    .Clock     (Clock),
    .Reset     (Reset),
    .Clear     (rxClear),
    .SymbolEdge(rxEdgeUnused),
    .Sample    (rxSample)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxState      <= RX_IDLE;
      rxShift      <= '0;
      rxBitCount   <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
    end else begin
      if (DataOutValid && DataOutReady) begin
        DataOutValid <= 1'b0;
      end
      case (rxState)
        RX_IDLE: begin
          if (!rxIn) begin
            rxState <= RX_START;
          end
        end
        RX_START: begin
          if (rxSample) begin
            if (rxIn) begin
              rxState <= RX_IDLE;
            end else begin
              rxBitCount <= '0;
              rxState    <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rxSample) begin
            rxShift    <= {rxIn, rxShift[DATA_BITS-1:1]};
            rxBitCount <= rxBitCount + 3'd1;
            if (rxBitCount == 3'(DATA_BITS - 1)) begin
              rxState <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          // A completed frame overrides the consume clear above; it is dropped on overrun
          if (rxSample) begin
            rxState <= RX_IDLE;
            if (!DataOutValid || DataOutReady) begin
              DataOut      <= rxShift;
              DataOutValid <= 1'b1;
            end
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Two cross-connected transceivers; expected bytes are queued per receiver and a
// monitor pops and compares them whenever a receiver hands a byte to its consumer.
module tb_uart_transceiver;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned BAUD    = 115_200;
  localparam int          SET     = CLK_HZ / BAUD;
  localparam int          LAT_MAX = 10 * SET + 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] aDataIn = '0, bDataIn = '0;
  logic       aDataInValid = 1'b0, bDataInValid = 1'b0;
  logic       aDataInReady, bDataInReady;
  logic [7:0] aDataOut, bDataOut;
  logic       aDataOutValid, bDataOutValid;
  logic       aDataOutReady = 1'b1, bDataOutReady = 1'b1;
  logic       aSIn, bSIn, aSOut, bSOut;
  logic       bLine = 1'b1;

  assign aSIn = bSOut;
  assign bSIn = aSOut & bLine;

  uart_transceiver #(.ClockFreq(CLK_HZ), .BaudRate(BAUD)) uA (
    .Clock(Clock), .Reset(Reset),
    .DataIn(aDataIn), .DataInValid(aDataInValid), .DataInReady(aDataInReady),
    .DataOut(aDataOut), .DataOutValid(aDataOutValid), .DataOutReady(aDataOutReady),
    .SIn(aSIn), .SOut(aSOut)
  );

  uart_transceiver #(.ClockFreq(CLK_HZ), .BaudRate(BAUD)) uB (
    .Clock(Clock), .Reset(Reset),
    .DataIn(bDataIn), .DataInValid(bDataInValid), .DataInReady(bDataInReady),
    .DataOut(bDataOut), .DataOutValid(bDataOutValid), .DataOutReady(bDataOutReady),
    .SIn(bSIn), .SOut(bSOut)
  );

  always #10 Clock = ~Clock;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] expA[$];
  logic [7:0] expB[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Scoreboard monitors: one per receiver
  always @(negedge Clock) begin
    logic [7:0] e;
    if (!Reset && bDataOutValid && bDataOutReady) begin
      if (expB.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL B unexpected byte: got 0x%0h, expected none at %0t", bDataOut, $time);
      end else begin
        e = expB.pop_front();
        check("B rx byte", 32'(bDataOut), 32'(e));
      end
    end
  end

  always @(negedge Clock) begin
    logic [7:0] e;
    if (!Reset && aDataOutValid && aDataOutReady) begin
      if (expA.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL A unexpected byte: got 0x%0h, expected none at %0t", aDataOut, $time);
      end else begin
        e = expA.pop_front();
        check("A rx byte", 32'(aDataOut), 32'(e));
      end
    end
  end

  // Transmit one byte from side 0 (A) or 1 (B); checks the line waveform mid-bit
  // against the 8N1 frame and the exact busy time of DataInReady.
  task automatic send(input bit side, input logic [7:0] data);
    int waitCnt = 0;
    int low = 0;
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    @(negedge Clock);
    while (!(side ? bDataInReady : aDataInReady) && waitCnt < 20 * SET) begin
      @(negedge Clock);
      waitCnt++;
    end
    if (!(side ? bDataInReady : aDataInReady)) begin
      check("tx ready timeout", 32'd0, 32'd1);
      return;
    end
    if (side) begin bDataIn = data; bDataInValid = 1'b1; end
    else      begin aDataIn = data; aDataInValid = 1'b1; end
    @(posedge Clock);
    #1;
    if (side) bDataInValid = 1'b0; else aDataInValid = 1'b0;
    while (low < 12 * SET) begin
      @(negedge Clock);
      if (side ? bDataInReady : aDataInReady) break;
      if (low < 10 * SET && (low % SET) == SET / 2)
        check(side ? "B tx line bit" : "A tx line bit",
              32'(side ? bSOut : aSOut), 32'(frame[low / SET]));
      low++;
    end
    check(side ? "B ready low cycles" : "A ready low cycles", 32'(low), 32'(10 * SET));
  endtask

  initial begin
    #(20 * 150_000);
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    int n;
    logic [7:0] ra, rb;

    // Reset values
    repeat (3) @(posedge Clock);
    #1;
    check("reset A SOut", 32'(aSOut), 32'd1);
    check("reset A DataInReady", 32'(aDataInReady), 32'd1);
    check("reset B DataOutValid", 32'(bDataOutValid), 32'd0);
    check("reset B DataOut", 32'(bDataOut), 32'd0);
    Reset = 1'b0;

    // Idle for 1000 cycles
    viol = 0;
    repeat (1000) begin
      @(negedge Clock);
      if (aSOut !== 1'b1 || bSOut !== 1'b1 || aDataInReady !== 1'b1 || bDataInReady !== 1'b1 ||
          aDataOutValid !== 1'b0 || bDataOutValid !== 1'b0)
        viol++;
    end
    check("idle hold violations", 32'(viol), 32'd0);

    // Single byte A->B with latency bound, consumer stalled until checked
    @(posedge Clock); #1 bDataOutReady = 1'b0;
    expB.push_back(8'h7a);
    fork
      send(0, 8'h7a);
      begin
        n = 0;
        while (aDataInReady && n < 40 * SET) begin @(negedge Clock); n++; end
        n = 0;
        while (!bDataOutValid && n < LAT_MAX + 50) begin @(negedge Clock); n++; end
        check("B valid within latency bound", 32'(bDataOutValid && n <= LAT_MAX), 32'd1);
      end
    join
    check("B DataOut 7a", 32'(bDataOut), 32'h7a);
    @(posedge Clock); #1 bDataOutReady = 1'b1;
    @(posedge Clock); #1;
    check("B valid cleared after consume", 32'(bDataOutValid), 32'd0);

    // Back-to-back extremes
    expB.push_back(8'h00);
    expB.push_back(8'hff);
    send(0, 8'h00);
    send(0, 8'hff);

    // Overrun: second byte dropped while the first is unconsumed
    @(posedge Clock); #1 bDataOutReady = 1'b0;
    expB.push_back(8'h55);
    send(0, 8'h55);
    send(0, 8'haa);
    repeat (20) @(negedge Clock);
    check("overrun B valid held", 32'(bDataOutValid), 32'd1);
    check("overrun B DataOut kept", 32'(bDataOut), 32'h55);
    @(posedge Clock); #1 bDataOutReady = 1'b1;
    @(posedge Clock); #1;
    check("overrun valid cleared by pulse", 32'(bDataOutValid), 32'd0);

    // One-cycle glitch on an idle receiver, then a real byte
    @(posedge Clock); #1 bLine = 1'b0;
    @(posedge Clock); #1 bLine = 1'b1;
    viol = 0;
    repeat (3 * SET) begin
      @(negedge Clock);
      if (bDataOutValid !== 1'b0) viol++;
    end
    check("glitch produced no byte", 32'(viol), 32'd0);
    expB.push_back(8'h3c);
    send(0, 8'h3c);
    repeat (20) @(negedge Clock);

    // Randomised full-duplex traffic
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      expB.push_back(ra);
      expA.push_back(rb);
      fork
        send(0, ra);
        send(1, rb);
      join
    end
    repeat (20) @(negedge Clock);

    // Reset mid-frame aborts at once and nothing is received
    @(negedge Clock);
    aDataIn = 8'ha5;
    aDataInValid = 1'b1;
    @(posedge Clock); #1 aDataInValid = 1'b0;
    check("a5 accepted", 32'(aDataInReady), 32'd0);
    repeat (2000) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    check("mid-frame reset SOut", 32'(aSOut), 32'd1);
    check("mid-frame reset DataInReady", 32'(aDataInReady), 32'd1);
    check("mid-frame reset B valid", 32'(bDataOutValid), 32'd0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    viol = 0;
    repeat (3000) begin
      @(negedge Clock);
      if (bDataOutValid !== 1'b0 || aSOut !== 1'b1) viol++;
    end
    check("no byte after aborted frame", 32'(viol), 32'd0);

    check("A queue drained", 32'(expA.size()), 32'd0);
    check("B queue drained", 32'(expB.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
